alu_exec_unit: RTL



---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_if.sv | 32 +++
 rtl/alu_mul_iter.sv | 60 ++++++
 rtl/alu_exec_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, FSM states and
// the Zero-flag helper used wherever a result is registered.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 5;

   localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
   localparam logic [OP_W-1:0] OP_ADDI = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
   localparam logic [OP_W-1:0] OP_MUL  = 5'd3;
   localparam logic [OP_W-1:0] OP_LW   = 5'd4;
   localparam logic [OP_W-1:0] OP_SW   = 5'd5;
   localparam logic [OP_W-1:0] OP_SB   = 5'd6;
   localparam logic [OP_W-1:0] OP_LH   = 5'd7;
   localparam logic [OP_W-1:0] OP_LB   = 5'd8;
   localparam logic [OP_W-1:0] OP_SH   = 5'd9;
   localparam logic [OP_W-1:0] OP_BGEZ = 5'd10;
   localparam logic [OP_W-1:0] OP_BEQ  = 5'd11;
   localparam logic [OP_W-1:0] OP_BNE  = 5'd12;
   localparam logic [OP_W-1:0] OP_BGTZ = 5'd13;
   localparam logic [OP_W-1:0] OP_BLEZ = 5'd14;
   localparam logic [OP_W-1:0] OP_BLTZ = 5'd15;
   localparam logic [OP_W-1:0] OP_J    = 5'd16;
   localparam logic [OP_W-1:0] OP_JR   = 5'd17;
   localparam logic [OP_W-1:0] OP_JAL  = 5'd18;
   localparam logic [OP_W-1:0] OP_AND  = 5'd19;
   localparam logic [OP_W-1:0] OP_ANDI = 5'd20;
   localparam logic [OP_W-1:0] OP_OR   = 5'd21;
   localparam logic [OP_W-1:0] OP_NOR  = 5'd22;
   localparam logic [OP_W-1:0] OP_XOR  = 5'd23;
   localparam logic [OP_W-1:0] OP_ORI  = 5'd24;
   localparam logic [OP_W-1:0] OP_XORI = 5'd25;
   localparam logic [OP_W-1:0] OP_SLL  = 5'd26;
   localparam logic [OP_W-1:0] OP_SRL  = 5'd27;
   localparam logic [OP_W-1:0] OP_SLT  = 5'd28;
   localparam logic [OP_W-1:0] OP_SLTI = 5'd29;

   // IDLE: single-cycle ops and acceptance; MUL: iterative multiply running
   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_t;

   // Zero flag travels with every registered result
   function automatic logic is_zero(input logic [DATA_W-1:0] value);
      return (value == '0);
   endfunction

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between an operation requester (master) and the
// ALU responder (slave).
//
// Handshake: a request transfers on a rising edge where InValid && InReady;
// a result transfers on a rising edge where OutValid && OutReady. While
// OutValid is high and OutReady low, ALUResult/Zero/OutValid hold steady.
// A result may drain and a new request be accepted on the same edge.
interface alu_if;
   import alu_pkg::*;

   logic              InValid;
   logic              InReady;
   logic [OP_W-1:0]   ALUControl;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              OutValid;
   logic              OutReady;
   logic [DATA_W-1:0] ALUResult;
   logic              Zero;
   logic              Busy;

   modport master (
      output InValid, ALUControl, A, B, OutReady,
      input  InReady, OutValid, ALUResult, Zero, Busy
   );

   modport slave (
      input  InValid, ALUControl, A, B, OutReady,
      output InReady, OutValid, ALUResult, Zero, Busy
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH
// bits of the product only. The final iteration's sum is presented
// combinationally on product while done is high, so the caller can load it
// on the same edge that would have performed that last iteration.
module alu_mul_iter #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(MUL_CYCLES);

   logic             active;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;

   assign acc_next = mplier[0] ? (acc + mcand) : acc;
   assign done     = active && (cnt == CNT_W'(MUL_CYCLES - 1));
   assign product  = acc_next;

   // Load operands on start, then step once per cycle; the last step waits
   // (everything frozen) while the caller's output slot is occupied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (active && !(done && stall)) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            active <= 1'b0;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU. Single-cycle ops register their result on
// the accept edge; multiply hands off to the iterative engine and the FSM
// waits in MUL until the product can be loaded into the output slot.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic       Clk,
   input  logic       Reset,
   alu_if.slave       bus,
   output alu_state_t dbg_state
);

   alu_state_t        state;
   logic              out_valid_q;
   logic [WIDTH-1:0]  result_q;
   logic              zero_q;
   logic              busy_q;

   logic              slot_free;
   logic              accept;
   logic              drain;
   logic              mul_start;
   logic              mul_done;
   logic [WIDTH-1:0]  mul_product;
   logic [WIDTH-1:0]  op_result;
   logic signed [WIDTH-1:0] sa;
   logic signed [WIDTH-1:0] sb;

   // The output slot can take a new value if it is empty or draining now
   assign slot_free  = !out_valid_q || bus.OutReady;
   assign bus.InReady = (state == IDLE) && slot_free;
   assign accept     = bus.InValid && bus.InReady;
   assign drain      = out_valid_q && bus.OutReady;
   assign mul_start  = accept && (bus.ALUControl == OP_MUL);

   assign sa = bus.A;
   assign sb = bus.B;

   // Combinational result for every single-cycle opcode
   always_comb begin
      op_result = '0;
      case (bus.ALUControl)
         OP_ADD, OP_ADDI, OP_LW, OP_SW,
         OP_SB, OP_LH, OP_LB, OP_SH:   op_result = bus.A + bus.B;
         OP_SUB:                       op_result = bus.A - bus.B;
         OP_MUL:                       op_result = '0;
         OP_BGEZ:                      op_result[0] = (sa >= 0);
         OP_BEQ:                       op_result[0] = (bus.A == bus.B);
         OP_BNE:                       op_result[0] = (bus.A != bus.B);
         OP_BGTZ:                      op_result[0] = (sa > 0);
         OP_BLEZ:                      op_result[0] = (sa <= 0);
         OP_BLTZ:                      op_result[0] = (sa < 0);
         OP_J, OP_JR, OP_JAL:          op_result = bus.A;
         OP_AND, OP_ANDI:              op_result = bus.A & bus.B;
         OP_OR, OP_ORI:                op_result = bus.A | bus.B;
         OP_NOR:                       op_result = ~(bus.A | bus.B);
         OP_XOR, OP_XORI:              op_result = bus.A ^ bus.B;
         OP_SLL:                       op_result = bus.A << bus.B[4:0];
         OP_SRL:                       op_result = bus.A >> bus.B[4:0];
         OP_SLT, OP_SLTI:              op_result[0] = (sa < sb);
         default:                      op_result = '0;
      endcase
   end

   alu_mul_iter #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (Clk),
      .rst     (Reset),
      .start   (mul_start),
      .stall   (!slot_free),
      .a       (bus.A),
      .b       (bus.B),
      .done    (mul_done),
      .product (mul_product)
   );

   // Control FSM owning the output register, Zero and Busy
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (drain) begin
                  out_valid_q <= 1'b0;
               end
               if (accept) begin
                  if (bus.ALUControl == OP_MUL) begin
                     state  <= MUL;
                     busy_q <= 1'b1;
                  end else begin
                     out_valid_q <= 1'b1;
                     result_q    <= op_result;
                     zero_q      <= is_zero(op_result);
                  end
               end
            end
            MUL: begin
               if (mul_done && slot_free) begin
                  state       <= IDLE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  result_q    <= mul_product;
                  zero_q      <= is_zero(mul_product);
               end else if (drain) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.OutValid  = out_valid_q;
   assign bus.ALUResult = result_q;
   assign bus.Zero      = zero_q;
   assign bus.Busy      = busy_q;
   assign dbg_state     = state;

endmodule
